// File: rtl/sdram_sc_fifo.sv
// Parametrised single-clock FIFO for SDRAM read-return / write-staging paths.
// Normal or show-ahead read mode, programmable level flags, sticky error flags.
module sdram_sc_fifo #(
    parameter int WIDTH     = 16,
    parameter int AW        = 6,
    parameter bit SHOWAHEAD = 1'b0,
    parameter int AF_LEVEL  = 2**AW - 4,
    parameter int AE_LEVEL  = 4
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      usedw,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    if (AW < 1) begin : g_chk_aw
        $error("sdram_sc_fifo: AW must be at least 1");
    end
    if (AF_LEVEL > DEPTH) begin : g_chk_af
        $error("sdram_sc_fifo: AF_LEVEL exceeds DEPTH");
    end
    if (AE_LEVEL > DEPTH) begin : g_chk_ae
        $error("sdram_sc_fifo: AE_LEVEL exceeds DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full_w, empty_w, wr_ok, rd_ok;
    logic [WIDTH-1:0] rdat;

    assign full_w  = (cnt_q == DEPTH_C);
    assign empty_w = (cnt_q == '0);
    // A full FIFO refuses writes even when a read frees a slot this cycle.
    assign wr_ok   = wrreq && !full_w && !sclr;
    assign rd_ok   = rdreq && !empty_w && !sclr;
    assign rdat    = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[wr_ptr_q] <= data;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        qr_d     = qr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            qr_d     = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                qr_d     = rdat;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
            ovf_d = ovf_q | (wrreq && full_w);
            unf_d = unf_q | (rdreq && empty_w);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            qr_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            qr_q     <= qr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Show-ahead drives the head word combinationally; forced to 0 while empty.
    if (SHOWAHEAD) begin : g_show
        assign q = empty_w ? '0 : rdat;
    end else begin : g_norm
        assign q = qr_q;
    end

    assign empty        = empty_w;
    assign full         = full_w;
    assign usedw        = cnt_q;
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q < AE_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sdram_sc_fifo.sv
// Bench for sdram_sc_fifo: normal and show-ahead instances share stimulus and
// are checked every cycle against a queue model, plus literal spot checks.
module tb_sdram_sc_fifo;
    localparam int W = 16, AW = 3, DEPTH = 8, AFL = 6, AEL = 2;

    logic          clock = 1'b0;
    logic          aclr = 1'b1, sclr = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [W-1:0]  data = '0;

    logic [W-1:0]  q_n, q_s;
    logic          empty_n, full_n, af_n, ae_n, ovf_n, unf_n;
    logic          empty_s, full_s, af_s, ae_s, ovf_s, unf_s;
    logic [AW:0]   usedw_n, usedw_s;

    sdram_sc_fifo #(.WIDTH(W), .AW(AW), .SHOWAHEAD(1'b0), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_norm (
        .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q_n), .empty(empty_n), .full(full_n), .almost_full(af_n), .almost_empty(ae_n),
        .usedw(usedw_n), .overflow(ovf_n), .underflow(unf_n));

    sdram_sc_fifo #(.WIDTH(W), .AW(AW), .SHOWAHEAD(1'b1), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_show (
        .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q_s), .empty(empty_s), .full(full_s), .almost_full(af_s), .almost_empty(ae_s),
        .usedw(usedw_s), .overflow(ovf_s), .underflow(unf_s));

    always #5 clock = ~clock;

    logic [W-1:0] mq [$];
    logic [W-1:0] m_qn = '0;
    bit           m_ovf = 1'b0, m_unf = 1'b0;
    int           checks = 0, errors = 0;
    bit           chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_qn  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(bit w, bit r, logic [W-1:0] d, bit sc);
        bit f, e;
        if (sc) begin
            model_clear();
        end else begin
            f = (mq.size() == DEPTH);
            e = (mq.size() == 0);
            if (w && f) m_ovf = 1'b1;
            if (r && e) m_unf = 1'b1;
            if (r && !e) m_qn = mq.pop_front();
            if (w && !f) mq.push_back(d);
        end
    endtask

    always @(negedge clock) begin
        int n;
        if (chk_en) begin
            n = mq.size();
            chk("usedw_n", 32'(usedw_n), n);
            chk("empty_n", 32'(empty_n), 32'(n == 0));
            chk("full_n",  32'(full_n),  32'(n == DEPTH));
            chk("af_n",    32'(af_n),    32'(n >= AFL));
            chk("ae_n",    32'(ae_n),    32'(n < AEL));
            chk("ovf_n",   32'(ovf_n),   32'(m_ovf));
            chk("unf_n",   32'(unf_n),   32'(m_unf));
            chk("q_n",     32'(q_n),     32'(m_qn));
            chk("usedw_s", 32'(usedw_s), n);
            chk("empty_s", 32'(empty_s), 32'(n == 0));
            chk("full_s",  32'(full_s),  32'(n == DEPTH));
            chk("af_s",    32'(af_s),    32'(n >= AFL));
            chk("ae_s",    32'(ae_s),    32'(n < AEL));
            chk("ovf_s",   32'(ovf_s),   32'(m_ovf));
            chk("unf_s",   32'(unf_s),   32'(m_unf));
            if (n > 0) chk("q_s", 32'(q_s), 32'(mq[0]));
        end
    end

    task automatic step(bit w, bit r, logic [W-1:0] d, bit sc);
        @(negedge clock);
        #1;
        wrreq = w; rdreq = r; data = d; sclr = sc;
        @(posedge clock);
        model_edge(w, r, d, sc);
    endtask

    task automatic cleared_lits(string tag);
        chk({tag, "_usedw"}, 32'(usedw_n), 0);
        chk({tag, "_empty"}, 32'(empty_n), 1);
        chk({tag, "_ae"},    32'(ae_n), 1);
        chk({tag, "_full"},  32'(full_n), 0);
        chk({tag, "_q"},     32'(q_n), 0);
        chk({tag, "_ovf"},   32'(ovf_n), 0);
        chk({tag, "_unf"},   32'(unf_n), 0);
    endtask

    task automatic pulse_aclr();
        @(negedge clock);
        #1;
        wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
        aclr = 1'b1;
        model_clear();
        #2;
        cleared_lits("aclr");
        @(posedge clock);
        @(negedge clock);
        #1;
        aclr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w, r, sc;
        int pw, pr;
        #7;
        cleared_lits("por");
        chk("por_af", 32'(af_n), 0);
        #5;
        aclr = 1'b0;
        chk_en = 1'b1;

        // Reset and clear
        step(1, 0, 16'h0011, 0);
        step(1, 0, 16'h0022, 0);
        step(1, 0, 16'h0033, 0);
        step(0, 1, 16'h0000, 0);
        #2 chk("t1_q_before_aclr", 32'(q_n), 32'h11);
        pulse_aclr();
        step(1, 0, 16'h0044, 0);
        step(1, 0, 16'h0055, 0);
        step(1, 0, 16'h0066, 1);
        #2 cleared_lits("sclr");
        step(0, 0, 16'h0000, 0);
        #2 chk("sclr_write_dropped", 32'(usedw_n), 0);

        // Fill and level flags
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 16'(i), 0);
            #2;
            if (i == 1) chk("fill_ae_1", 32'(ae_n), 1);
            if (i == 2) chk("fill_ae_2", 32'(ae_n), 0);
            if (i == 5) chk("fill_af_5", 32'(af_n), 0);
            if (i == 6) chk("fill_af_6", 32'(af_n), 1);
            if (i == 7) chk("fill_full_7", 32'(full_n), 0);
            if (i == 8) begin
                chk("fill_full_8", 32'(full_n), 1);
                chk("fill_usedw_8", 32'(usedw_n), 8);
            end
        end
        step(1, 0, 16'h0099, 0);
        #2;
        chk("ovf_set", 32'(ovf_n), 1);
        chk("ovf_usedw", 32'(usedw_n), 8);

        // Drain, wrap, underflow
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 16'h0000, 0);
            #2 chk("drain_q", 32'(q_n), i);
        end
        chk("drain_empty", 32'(empty_n), 1);
        step(1, 0, 16'hA5A5, 0);
        step(0, 1, 16'h0000, 0);
        #2 chk("wrap_q", 32'(q_n), 32'hA5A5);
        step(0, 1, 16'h0000, 0);
        #2;
        chk("unf_set", 32'(unf_n), 1);
        chk("unf_q_hold", 32'(q_n), 32'hA5A5);

        // Simultaneous read and write
        step(0, 0, 16'h0000, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 16'($urandom), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 16'($urandom), 0);
            #2 chk("rw_usedw", 32'(usedw_n), 4);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 16'($urandom), 0);
        step(1, 1, 16'hBEEF, 0);
        #2;
        chk("rwfull_usedw", 32'(usedw_n), 7);
        chk("rwfull_ovf", 32'(ovf_n), 1);
        chk("rwfull_full", 32'(full_n), 0);

        // Show-ahead
        step(0, 0, 16'h0000, 1);
        step(1, 0, 16'h1234, 0);
        #2;
        chk("sa_empty", 32'(empty_s), 0);
        chk("sa_q_first", 32'(q_s), 32'h1234);
        step(1, 0, 16'h5678, 0);
        step(0, 1, 16'h0000, 0);
        #2 chk("sa_q_next", 32'(q_s), 32'h5678);
        step(0, 1, 16'h0000, 0);
        #2 chk("sa_empty_end", 32'(empty_s), 1);

        // Randomised bursts
        step(0, 0, 16'h0000, 1);
        for (int c = 0; c < 2000; c++) begin
            case ((c / 200) % 4)
                0: begin pw = 80; pr = 30; end
                1: begin pw = 30; pr = 80; end
                2: begin pw = 50; pr = 50; end
                default: begin pw = 95; pr = 90; end
            endcase
            w  = ($urandom_range(99) < pw);
            r  = ($urandom_range(99) < pr);
            sc = ($urandom_range(399) == 0);
            step(w, r, 16'($urandom), sc);
        end
        step(0, 0, 16'h0000, 0);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
